// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and constants for the register-file write arbiter slice.
package regfile_write_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;
  // Architectural zero register; writes to it are discarded.
  localparam int unsigned X0_IDX     = 0;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous {rd,data} FIFO with occupancy count and a per-entry valid/rd view.
module regfile_wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [REG_AW-1:0]              push_rd,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [REG_AW-1:0]              head_rd,
  output logic [DATA_W-1:0]              head_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   entry_rd
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [REG_AW-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // Slot i is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
      entry_rd[i]    = mem_rd[i];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-bank write port between WB and a buffered late-response unit.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned REG_AW       = DEF_REG_AW,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_valid,
  input  logic [REG_AW-1:0]             wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  output logic                          wb_ready,
  input  logic                          lsu_valid,
  input  logic [REG_AW-1:0]             lsu_rd,
  input  logic [DATA_W-1:0]             lsu_data,
  output logic                          lsu_ready,
  output logic                          rf_we,
  output logic [REG_AW-1:0]             rf_rd,
  output logic [DATA_W-1:0]             rf_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2**REG_AW-1:0]          pend_mask
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0]                  age;
  logic                              fifo_nonempty;
  logic                              starved;
  logic                              wb_wr;
  logic                              push;
  logic                              pop;
  logic [REG_AW-1:0]                 head_rd;
  logic [DATA_W-1:0]                 head_data;
  logic [FIFO_DEPTH-1:0]             entry_valid;
  logic [FIFO_DEPTH-1:0][REG_AW-1:0] entry_rd;

  assign fifo_nonempty = fifo_count != '0;
  assign starved       = fifo_nonempty && (age >= AGE_W'(STARVE_LIMIT));
  assign wb_ready      = !rst && !starved;
  assign lsu_ready     = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));

  // x0 requests still handshake but never reach the bank or the buffer.
  assign wb_wr = wb_valid && wb_ready && (wb_rd != REG_AW'(X0_IDX));
  assign push  = lsu_valid && lsu_ready && (lsu_rd != REG_AW'(X0_IDX));
  assign pop   = !rst && !wb_wr && fifo_nonempty;

  regfile_wr_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_rd     (lsu_rd),
    .push_data   (lsu_data),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // WB wins unless the buffered head has aged out; idle cycles hold rd/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      age     <= '0;
    end else begin
      rf_we <= wb_wr || pop;
      if (wb_wr) begin
        rf_rd   <= wb_rd;
        rf_data <= wb_data;
        if (fifo_nonempty && (age < AGE_W'(STARVE_LIMIT))) age <= age + AGE_W'(1);
      end else if (pop) begin
        rf_rd   <= head_rd;
        rf_data <= head_data;
        age     <= '0;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) pend_mask[entry_rd[i]] = 1'b1;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register bank's single write port (rd / RegWrite / C) between two writers.
- Writer 0: the pipeline WB stage.
- Writer 1: the late-response unit (loads / multi-cycle ops). It is buffered in a small FIFO with starvation protection.
- Outputs are registered and drive the register bank directly. A pending-rd mask is exported to the hazard unit.

Parameters:
- DATA_W, 32, write data width
- REG_AW, 5, register index width
- FIFO_DEPTH, 4, writer-1 buffer entries (power of 2, >=2)
- STARVE_LIMIT, 3, cycles the FIFO head may lose to WB before WB is stalled (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  WB write request
- wb_rd  in  REG_AW  WB destination
- wb_data  in  DATA_W  WB data
- wb_ready  out  1  WB request accepted this cycle (pipeline stalls when 0)
- lsu_valid  in  1  late-unit write request
- lsu_rd  in  REG_AW  late-unit destination
- lsu_data  in  DATA_W  late-unit data
- lsu_ready  out  1  FIFO can accept
- rf_we  out  1  to register bank RegWrite
- rf_rd  out  REG_AW  to register bank rd
- rf_data  out  DATA_W  to register bank C
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
- pend_mask  out  2**REG_AW  one-hot OR of rd of every valid FIFO entry

Behaviour:
- Reset (rst=1 at clk edge):
  - rf_we=0, rf_rd=0, rf_data=0.
  - FIFO emptied: pointers 0, fifo_count=0, pend_mask=0.
  - age counter = 0.
  - While rst=1, wb_ready=0 and lsu_ready=0 (combinationally gated).
  - Reset mid-operation discards all buffered entries; no write is issued for them.
- Handshake: a transfer occurs on valid&&ready at a rising edge. Data is sampled only then.
- Ready generation:
  - lsu_ready = !rst && fifo_count<FIFO_DEPTH. There is no same-cycle pop credit: when full, ready stays 0 even if a pop occurs.
  - wb_ready = !rst && !(fifo_count!=0 && age>=STARVE_LIMIT).
- x0 filtering:
  - An accepted WB request with wb_rd==0 produces no write.
  - An accepted LSU request with lsu_rd==0 is accepted and dropped: no push, no count change.
- Grant, evaluated each cycle (at most one write per cycle):
  - Case 1 — WB fire with wb_rd!=0:
    - Next edge: rf_we=1, rf_rd=wb_rd, rf_data=wb_data.
    - If FIFO non-empty, age increments, saturating at STARVE_LIMIT.
  - Case 2 — otherwise, FIFO non-empty:
    - Pop head. Next edge: rf_we=1 with the head's rd/data.
    - age=0.
  - Case 3 — otherwise: rf_we=0 next edge; rf_rd/rf_data hold previous values.
- Latency:
  - WB: accept at edge N -> rf_we=1 during cycle N+1 (1 cycle).
  - LSU: push at edge N -> entry visible at N+1 -> earliest rf_we during cycle N+2. An empty FIFO is not bypassed.
  - rf_we is a single-cycle pulse per granted write.
- Simultaneous events:
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A push into a full FIFO cannot occur (ready=0).
- Ordering:
  - FIFO entries are written in arrival order.
  - WB vs FIFO ordering to the same rd is not resolved here. The hazard unit uses pend_mask to prevent it.
- Pointer wrap: read and write pointers are modulo FIFO_DEPTH. fifo_count distinguishes full from empty.
- pend_mask:
  - Combinational from FIFO valid entries.
  - A bit clears in the cycle after the entry pops, i.e. while its rf_we is high.

Decomposition:
- Shared package: REG_AW and DATA_W defaults, and the x0 index constant.
- Natural sub-module: regfile_wr_fifo, a synchronous FIFO of {rd,data} with count output and a per-entry valid/rd view for pend_mask.
- Arbitration, age counter and output registers stay in the top.

Test Plan:
- Reset: hold rst 3 cycles with both valids high -> rf_we=0, rf_rd=0, rf_data=0, fifo_count=0, pend_mask=0, wb_ready=lsu_ready=0. After release, both readies=1.
- WB only: wb rd=5 data=0xDEADBEEF accepted at edge N -> cycle N+1 rf_we=1, rf_rd=5, rf_data=0xDEADBEEF; cycle N+2 rf_we=0.
- LSU only: lsu rd=7 data=0x12345678 pushed at edge N -> N+1 pend_mask=0x80, fifo_count=1; N+2 rf_we=1 rf_rd=7, pend_mask=0, fifo_count=0.
- x0 drop: wb rd=0, and separately lsu rd=0 -> rf_we never asserts, fifo_count stays 0, both readies stay 1.
- Starvation, STARVE_LIMIT=3:
  - Stimulus: one LSU entry (rd=9) present; WB valid every cycle (rd=1..).
  - Three WB writes occur, then wb_ready=0 for one cycle, rf_rd=9 written, then wb_ready=1 again.
- Full + reset:
  - Continuous WB with 4 LSU pushes (rd=10..13), STARVE_LIMIT raised: lsu_ready=0 at fifo_count=4.
  - Assert rst mid-stream: next cycle fifo_count=0, pend_mask=0, and no writes to rd 10..13 ever appear.
